// File: rtl/pixel_stream_packer_pkg.sv
// rtl/pixel_stream_packer_pkg.sv - shared constants and state encoding for the pixel stream packer
package pixel_stream_pkg;

    localparam logic MODE_RGB888   = 1'b0;
    localparam logic MODE_RGBX8888 = 1'b1;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_stream_packer_if.sv
// rtl/pixel_stream_packer_if.sv - pixel input handshake and AXI-Stream video output bundle
interface pixel_stream_packer_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BPW = DATA_WIDTH / 8;

    logic [7:0]            in_r;
    logic [7:0]            in_g;
    logic [7:0]            in_b;
    logic                  in_sof;
    logic                  in_eol;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_tdata;
    logic [BPW-1:0]        out_tkeep;
    logic                  out_tlast;
    logic                  out_tuser;
    logic                  out_tvalid;
    logic                  out_tready;

    modport master (
        output in_r, in_g, in_b, in_sof, in_eol, in_valid, out_tready,
        input  in_ready, out_tdata, out_tkeep, out_tlast, out_tuser, out_tvalid
    );

    modport slave (
        input  in_r, in_g, in_b, in_sof, in_eol, in_valid, out_tready,
        output in_ready, out_tdata, out_tkeep, out_tlast, out_tuser, out_tvalid
    );
endinterface

// File: rtl/pixel_stream_packer_accumulator.sv
// rtl/pixel_stream_packer_accumulator.sv - residual byte register and full-word/remainder split
module pixel_byte_accumulator #(
    parameter int BPW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             restart,
    input  logic             drain,
    input  logic             eol,
    input  logic [31:0]      pix,
    input  logic [2:0]       add,
    output logic             full,
    output logic [BPW*8-1:0] full_word,
    output logic [BPW*8-1:0] rem_word,
    output logic [BPW*8-1:0] residual,
    output logic [7:0]       rem_count,
    output logic [7:0]       count
);
    localparam int W = (BPW + 4) * 8;

    logic [7:0]   base;
    logic [7:0]   total;
    logic [W-1:0] merged;
    logic [W-1:0] shifted;

    // Residual bytes above count are kept zero so OR-merging the new pixel is safe.
    always_comb begin
        base      = restart ? 8'd0 : count;
        total     = base + {5'd0, add};
        merged    = (restart ? {W{1'b0}} : W'(residual)) | (W'(pix) << {base, 3'b000});
        shifted   = merged >> (BPW * 8);
        full      = total >= 8'(BPW);
        full_word = merged[BPW*8-1:0];
        rem_word  = full ? shifted[BPW*8-1:0] : merged[BPW*8-1:0];
        rem_count = full ? total - 8'(BPW) : total;
    end

    // An eol with a full word and leftover bytes keeps the leftovers here until drained.
    always_ff @(posedge clk) begin
        if (reset || drain) begin
            count    <= 8'd0;
            residual <= '0;
        end else if (load) begin
            if (eol && !full) begin
                count    <= 8'd0;
                residual <= '0;
            end else begin
                count    <= rem_count;
                residual <= rem_word;
            end
        end
    end
endmodule

// File: rtl/pixel_stream_packer.sv
// rtl/pixel_stream_packer.sv - RGB888 pixel to AXI-Stream video word packer with eol flush and sync check
module pixel_stream_packer
    import pixel_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    pixel_stream_packer_if.slave bus,
    output logic                 sync_err
);
    localparam int BPW = DATA_WIDTH / 8;

    state_t                state;
    logic                  mode_q;
    logic                  sof_pend;
    logic                  accept;
    logic                  out_hs;
    logic                  mode_eff;
    logic [31:0]           pix;
    logic [2:0]            add;
    logic                  full;
    logic [DATA_WIDTH-1:0] full_word;
    logic [DATA_WIDTH-1:0] rem_word;
    logic [DATA_WIDTH-1:0] residual;
    logic [7:0]            rem_count;
    logic [7:0]            count;
    logic [DATA_WIDTH-1:0] tdata;
    logic [BPW-1:0]        tkeep;
    logic                  tlast;
    logic                  tuser;
    logic                  tvalid;

    function automatic logic [BPW-1:0] keep_mask(input logic [7:0] n);
        logic [BPW-1:0] ones;
        ones = {BPW{1'b1}};
        return ~(ones << n);
    endfunction

    assign bus.in_ready   = !reset && (state == ST_RUN) && (!tvalid || bus.out_tready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign out_hs         = tvalid && bus.out_tready;
    assign mode_eff       = bus.in_sof ? mode : mode_q;
    assign add            = (mode_eff == MODE_RGBX8888) ? 3'd4 : 3'd3;
    assign pix            = {(mode_eff == MODE_RGBX8888) ? PAD_BYTE : 8'h00, bus.in_r, bus.in_g, bus.in_b};
    assign bus.out_tdata  = tdata;
    assign bus.out_tkeep  = tkeep;
    assign bus.out_tlast  = tlast;
    assign bus.out_tuser  = tuser;
    assign bus.out_tvalid = tvalid;

    pixel_byte_accumulator #(.BPW(BPW)) u_acc (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .restart   (accept && bus.in_sof),
        .drain     ((state == ST_FLUSH) && out_hs),
        .eol       (bus.in_eol),
        .pix       (pix),
        .add       (add),
        .full      (full),
        .full_word (full_word),
        .rem_word  (rem_word),
        .residual  (residual),
        .rem_count (rem_count),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            mode_q   <= MODE_RGB888;
            sof_pend <= 1'b0;
            tdata    <= '0;
            tkeep    <= '0;
            tlast    <= 1'b0;
            tuser    <= 1'b0;
            tvalid   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= accept && bus.in_sof && (count != 8'd0);
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (bus.in_sof) mode_q <= mode;
                        if (full || bus.in_eol) begin
                            tvalid   <= 1'b1;
                            tuser    <= bus.in_sof || sof_pend;
                            sof_pend <= 1'b0;
                            tdata    <= full ? full_word : rem_word;
                            tkeep    <= full ? {BPW{1'b1}} : keep_mask(rem_count);
                            tlast    <= bus.in_eol && (!full || rem_count == 8'd0);
                            if (full && bus.in_eol && rem_count != 8'd0) state <= ST_FLUSH;
                        end else begin
                            sof_pend <= sof_pend || bus.in_sof;
                            if (out_hs) tvalid <= 1'b0;
                        end
                    end else if (out_hs) begin
                        tvalid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // The sof pixel, if any, already went out in the full word.
                    if (out_hs) begin
                        tdata <= residual;
                        tkeep <= keep_mask(count);
                        tlast <= 1'b1;
                        tuser <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb/tb_pixel_stream_packer.sv - self-checking bench for pixel_stream_packer with a byte-queue reference model
module tb_pixel_stream_packer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic        gate;
        logic        hidden;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mode_a = 1'b0;
    logic mode_b = 1'b0;
    logic sync_a;
    logic sync_b;
    logic rdy_rand = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int stall_cnt = 0;
    int sync_cnt = 0;
    int sync_b_cnt = 0;

    word_t exq[$];
    word_t got[$];
    logic [7:0] cur[$];
    logic mode_m = 1'b0;
    logic user_pend = 1'b0;
    logic flush_m = 1'b0;
    logic exp_sync = 1'b0;
    logic rst_prev = 1'b1;

    logic [63:0] d64[$];
    logic [7:0]  k64[$];
    logic        l64[$];
    logic        u64[$];

    always #5 clk = ~clk;

    pixel_stream_packer_if #(.DATA_WIDTH(32)) ifa ();
    pixel_stream_packer_if #(.DATA_WIDTH(64)) ifb ();

    pixel_stream_packer #(.DATA_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .mode(mode_a), .bus(ifa), .sync_err(sync_a)
    );
    pixel_stream_packer #(.DATA_WIDTH(64)) dut_b (
        .clk(clk), .reset(reset), .mode(mode_b), .bus(ifb), .sync_err(sync_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: bytes of the current line sit in a queue, words are cut every 4 bytes.
    task automatic model_accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic sof, input logic eol, input logic md);
        word_t w;
        int n;
        logic fl;
        fl = 1'b0;
        if (sof) begin
            if (cur.size() != 0) exp_sync = 1'b1;
            cur.delete();
            mode_m = md;
            user_pend = 1'b1;
        end
        cur.push_back(b); cur.push_back(g); cur.push_back(r);
        if (mode_m) cur.push_back(8'h00);
        if (cur.size() >= 4) begin
            w = '{default: 0};
            for (int i = 0; i < 4; i++) w.data[8*i +: 8] = cur.pop_front();
            w.keep = 4'hF;
            w.user = user_pend;
            user_pend = 1'b0;
            w.last = eol && cur.size() == 0;
            w.gate = eol && cur.size() != 0;
            fl = w.gate;
            exq.push_back(w);
        end
        if (eol && cur.size() != 0) begin
            n = cur.size();
            w = '{default: 0};
            for (int i = 0; i < n; i++) w.data[8*i +: 8] = cur.pop_front();
            w.keep = 4'((1 << n) - 1);
            w.last = 1'b1;
            w.user = user_pend;
            user_pend = 1'b0;
            w.hidden = fl;
            if (fl) flush_m = 1'b1;
            exq.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        word_t w;
        word_t h;
        logic exp_tv;
        exp_tv = exq.size() != 0 && !exq[0].hidden;
        if (rst_prev) begin
            check("rst_tvalid", ifa.out_tvalid, 0);
            check("rst_tdata", ifa.out_tdata, 0);
            check("rst_tkeep", ifa.out_tkeep, 0);
            check("rst_tlast", ifa.out_tlast, 0);
            check("rst_tuser", ifa.out_tuser, 0);
            check("rst_sync", sync_a, 0);
        end else begin
            check("tvalid", ifa.out_tvalid, exp_tv);
            if (exp_tv) begin
                check("tdata", ifa.out_tdata, exq[0].data);
                check("tkeep", ifa.out_tkeep, exq[0].keep);
                check("tlast", ifa.out_tlast, exq[0].last);
                check("tuser", ifa.out_tuser, exq[0].user);
            end
            check("sync_err", sync_a, exp_sync);
        end
        check("in_ready", ifa.in_ready, !reset && !flush_m && !(exp_tv && !ifa.out_tready));
        if (sync_a) sync_cnt++;
        if (!reset && !ifa.in_ready && ifa.out_tready) stall_cnt++;
        exp_sync = 1'b0;
        if (reset) begin
            exq.delete(); cur.delete();
            mode_m = 1'b0; user_pend = 1'b0; flush_m = 1'b0; rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (ifa.out_tvalid && ifa.out_tready && exq.size() != 0) begin
                w = exq.pop_front();
                got.push_back(w);
                if (w.gate) begin
                    flush_m = 1'b0;
                    if (exq.size() != 0) begin
                        h = exq.pop_front();
                        h.hidden = 1'b0;
                        exq.push_front(h);
                    end
                end
            end
            if (ifa.in_valid && ifa.in_ready)
                model_accept(ifa.in_r, ifa.in_g, ifa.in_b, ifa.in_sof, ifa.in_eol, mode_a);
        end
    end

    always @(negedge clk) begin
        if (!reset && ifb.out_tvalid && ifb.out_tready) begin
            d64.push_back(ifb.out_tdata); k64.push_back(ifb.out_tkeep);
            l64.push_back(ifb.out_tlast); u64.push_back(ifb.out_tuser);
        end
        if (sync_b) sync_b_cnt++;
    end

    initial begin
        ifa.out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 ifa.out_tready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    task automatic send_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic sof, input logic eol, input logic md);
        logic acc;
        acc = 1'b0;
        ifa.in_r = r; ifa.in_g = g; ifa.in_b = b;
        ifa.in_sof = sof; ifa.in_eol = eol; mode_a = md; ifa.in_valid = 1'b1;
        for (int n = 0; n < 2000 && !acc; n++) begin
            @(negedge clk);
            acc = ifa.in_ready;
        end
        @(posedge clk);
        #1 ifa.in_valid = 1'b0;
        if (!acc) check("send_a_timeout", 0, 1);
    endtask

    task automatic send_b(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic sof, input logic eol);
        logic acc;
        acc = 1'b0;
        ifb.in_r = r; ifb.in_g = g; ifb.in_b = b;
        ifb.in_sof = sof; ifb.in_eol = eol; ifb.in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = ifb.in_ready;
        end
        @(posedge clk);
        #1 ifb.in_valid = 1'b0;
        if (!acc) check("send_b_timeout", 0, 1);
    endtask

    task automatic drain_a();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 5000 && !done; n++) begin
            @(negedge clk);
            done = exq.size() == 0 && !ifa.out_tvalid;
        end
        @(posedge clk);
        #1;
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int lasts;
        ifa.in_valid = 0; ifa.in_sof = 0; ifa.in_eol = 0; ifa.in_r = 0; ifa.in_g = 0; ifa.in_b = 0;
        ifb.in_valid = 0; ifb.in_sof = 0; ifb.in_eol = 0; ifb.in_r = 0; ifb.in_g = 0; ifb.in_b = 0;
        ifb.out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        got.delete();
        send_a(8'h11, 8'h22, 8'h33, 1, 0, 0);
        send_a(8'h44, 8'h55, 8'h66, 0, 0, 0);
        send_a(8'h77, 8'h88, 8'h99, 0, 0, 0);
        send_a(8'hAA, 8'hBB, 8'hCC, 0, 1, 0);
        drain_a();
        check("t1_count", got.size(), 3);
        check("t1_w0", got[0].data, 32'h66112233);
        check("t1_w0_user", got[0].user, 1);
        check("t1_w1", got[1].data, 32'h88994455);
        check("t1_w2", got[2].data, 32'hAABBCC77);
        check("t1_w2_last", got[2].last, 1);
        check("t1_w2_keep", got[2].keep, 4'hF);

        got.delete(); stall_cnt = 0;
        send_a(8'h11, 8'h22, 8'h33, 0, 0, 0);
        send_a(8'h44, 8'h55, 8'h66, 0, 0, 0);
        send_a(8'h77, 8'h88, 8'h99, 0, 1, 0);
        drain_a();
        check("t2_stall", stall_cnt, 1);
        check("t2_count", got.size(), 3);
        check("t2_w1_last", got[1].last, 0);
        check("t2_w2", got[2].data, 32'h00000077);
        check("t2_w2_keep", got[2].keep, 4'h1);
        check("t2_w2_last", got[2].last, 1);

        got.delete(); stall_cnt = 0;
        send_a(8'h11, 8'h22, 8'h33, 1, 0, 1);
        send_a(8'h44, 8'h55, 8'h66, 0, 1, 1);
        drain_a();
        check("t3_stall", stall_cnt, 0);
        check("t3_w0", got[0].data, 32'h00112233);
        check("t3_w1", got[1].data, 32'h00445566);
        check("t3_w1_last", got[1].last, 1);

        got.delete(); rdy_rand = 1'b1;
        for (int i = 0; i < 1280; i++)
            send_a(8'($urandom), 8'($urandom), 8'($urandom), i == 0, i == 1279, 0);
        drain_a();
        lasts = 0;
        foreach (got[i]) if (got[i].last) lasts++;
        check("t4_count", got.size(), 960);
        check("t4_lasts", lasts, 1);
        check("t4_final_last", got[959].last, 1);
        rdy_rand = 1'b0;

        got.delete(); sync_cnt = 0;
        send_a(8'h11, 8'h22, 8'h33, 1, 0, 0);
        send_a(8'h44, 8'h55, 8'h66, 0, 0, 0);
        send_a(8'h77, 8'h88, 8'h99, 1, 0, 0);
        send_a(8'hAA, 8'hBB, 8'hCC, 0, 1, 0);
        drain_a();
        check("t5_sync_pulses", sync_cnt, 1);
        check("t5_count", got.size(), 3);
        check("t5_w1", got[1].data, 32'hCC778899);
        check("t5_w1_user", got[1].user, 1);
        check("t5_w2", got[2].data, 32'h0000AABB);
        check("t5_w2_keep", got[2].keep, 4'h3);

        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send_a(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(15, 0) == 0,
                   i == 399 || $urandom_range(7, 0) == 0, 1'($urandom_range(1, 0)));
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
        end
        drain_a();
        rdy_rand = 1'b0;

        d64.delete(); k64.delete(); l64.delete(); u64.delete();
        for (int i = 0; i < 5; i++)
            send_b(8'(3*i+3), 8'(3*i+2), 8'(3*i+1), i == 0, i == 4);
        repeat (4) @(negedge clk);
        check("t6_count", d64.size(), 2);
        check("t6_w0", d64[0], 64'h0807060504030201);
        check("t6_w0_keep", k64[0], 8'hFF);
        check("t6_w0_user", u64[0], 1);
        check("t6_w0_last", l64[0], 0);
        check("t6_w1", d64[1], 64'h000F0E0D0C0B0A09);
        check("t6_w1_keep", k64[1], 8'h7F);
        check("t6_w1_last", l64[1], 1);

        @(posedge clk); #1 ifb.out_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_b(8'h40 + 8'(i), 8'h50, 8'h60, 0, 0);
        @(negedge clk);
        check("t6_pending", ifb.out_tvalid, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("t6_rst_tvalid", ifb.out_tvalid, 0);
        check("t6_rst_tdata", ifb.out_tdata, 0);
        check("t6_rst_tkeep", ifb.out_tkeep, 0);
        ifb.out_tready = 1'b1;
        d64.delete(); k64.delete(); l64.delete(); u64.delete(); sync_b_cnt = 0;
        send_b(8'h33, 8'h22, 8'h11, 1, 1);
        repeat (3) @(negedge clk);
        check("t6_post_count", d64.size(), 1);
        check("t6_post_w", d64[0], 64'h0000000000332211);
        check("t6_post_keep", k64[0], 8'h07);
        check("t6_post_user_last", {u64[0], l64[0]}, 2'b11);
        check("t6_post_sync", sync_b_cnt, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Parametrised successor to the fixed RGB888-to-32-bit pixel packer.
- Accepts one RGB888 pixel per handshake, with start-of-frame and end-of-line flags, from the fractal/pixel compute pipeline.
- Emits an AXI4-Stream video bus of configurable width, in either tightly packed 24bpp or padded 32bpp mode.
- Flushes partial words at end-of-line with a correct tkeep, and detects frame-sync errors.

Parameters:
- DATA_WIDTH, 32, output tdata width in bits; allowed values 32, 64, 128.
- BPW, DATA_WIDTH/8, bytes per output word (derived localparam, not overridable).

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = RGB888 packed (3 bytes/pixel), 1 = RGBX8888 (4 bytes/pixel, pad byte 0x00).
- in_r, in_g, in_b  in  8 each  pixel colour.
- in_sof  in  1  pixel is the first pixel of a frame.
- in_eol  in  1  pixel is the last pixel of a line.
- in_valid  in  1  pixel is valid.
- in_ready  out  1  block accepts the pixel this cycle.
- out_tdata  out  DATA_WIDTH  packed bytes.
- out_tkeep  out  BPW  byte enables.
- out_tlast  out  1  last word of a line.
- out_tuser  out  1  first word of a frame.
- out_tvalid  out  1  word valid.
- out_tready  in  1  downstream accepts the word.
- sync_err  out  1  one-cycle pulse on a frame-sync error.

Behaviour:
- Reset, while reset is high: out_tvalid=0; out_tdata=0; out_tkeep=0; out_tlast=0; out_tuser=0; sync_err=0; in_ready=0; accumulator count=0; latched mode=0; state=RUN. in_ready may rise in the cycle after reset falls.
- A reset asserted mid-frame discards all accumulated bytes and any pending word.
- Byte order: each pixel appends b, g, r (then 0x00 when mode=1) at increasing byte lanes. Byte lane 0 = tdata[7:0]. Bytes carry over across word boundaries with no gaps.
- Mode latching: mode is sampled only when a pixel with in_sof is accepted. That pixel and the rest of the frame use the latched value.
- Accept condition: a pixel is accepted when in_valid && in_ready, with in_ready = (state==RUN) && (!out_tvalid || out_tready).
- Accumulator: holds 0..BPW-1 residual bytes. Each accepted pixel adds 3 or 4 bytes.
  - When count+add >= BPW, one full word (tkeep all ones) is registered.
  - It appears on out_tvalid in the next cycle (latency 1 cycle).
  - The remainder (count+add-BPW) stays in the accumulator.
- End-of-line flush, for an accepted pixel with in_eol:
  - No full word and remainder>0: register a partial word, tkeep = low (remainder) bits set, unused tdata bytes 0, tlast=1.
  - Full word produced and remainder=0: the full word carries tlast=1.
  - Full word produced and remainder>0: register the full word with tlast=0 and go to FLUSH. In FLUSH, in_ready=0. When that word is accepted, register the partial word with tlast=1 and return to RUN.
  - The accumulator is always empty after an eol flush.
- tuser: set on the first output word containing any byte of an in_sof pixel, and on no other word.
- Sync error: an in_sof pixel accepted while count!=0 means the previous line was missing its eol.
  - The residual bytes are dropped and not emitted.
  - sync_err pulses high for one cycle.
  - Packing restarts at lane 0 with the sof pixel.
- AXI-Stream rule: while out_tvalid=1 and out_tready=0, tdata, tkeep, tlast and tuser hold stable. out_tvalid never drops without a handshake.
- Backpressure: out_tready held low stalls the input via in_ready. No pixel is lost or duplicated.
- Simultaneous events: an output handshake and a pixel accept in the same cycle are legal. The new word replaces the accepted one with no bubble, giving full throughput of 1 pixel/clk in RUN.
- in_sof and in_eol both set on one pixel (a 1-pixel line) is legal: tuser=1 and tlast=1 on the same partial word.

Decomposition:
- Shared package pixel_stream_pkg holds:
  - mode constants MODE_RGB888=1'b0 and MODE_RGBX8888=1'b1;
  - state encodings ST_RUN and ST_FLUSH;
  - PAD_BYTE=8'h00.
- A single sub-module, pixel_byte_accumulator, is natural. It handles the residual shift register and the word/remainder split, and is combinational plus residual register.
- The top handles the FSM, mode latching, the output register and the flags.

Test Plan (DATA_WIDTH=32 unless stated):
1. mode=0; pixels (r,g,b) = (11,22,33), (44,55,66), (77,88,99), (AA,BB,CC) hex, sof on the first, eol on the fourth, out_tready=1. Expect exactly 3 words: 0x66112233 (tuser=1), 0x88994455, 0xAABBCC77 (tlast=1), all tkeep=0xF.
2. mode=0; 3-pixel line with eol on the third pixel. Expect a full word with tlast=0, in_ready low for exactly 1 cycle (FLUSH), then a partial word with tkeep=0x1, tlast=1, upper bytes 0.
3. mode=1; 2-pixel line (11,22,33), (44,55,66) with eol. Expect 0x00112233 then 0x00445566 (tlast=1), with no FLUSH stall.
4. out_tready toggled with a pseudo-random 50% duty over a 1280-pixel mode=0 line. Expect 960 words, payload matching a scoreboard, data held stable while stalled, one tlast on the final word.
5. Second sof sent after 2 pixels with no eol. Expect a sync_err pulse of 1 cycle, the 2 residual bytes never emitted, and the next word starting with the new sof pixel with tuser=1.
6. DATA_WIDTH=64, mode=0, 5-pixel line with eol. Expect one full word, then a partial word with tkeep=0x7F and tlast=1. Then assert reset mid-line on the next line: outputs return to reset values in the next cycle, and the following frame packs from lane 0.
